// File: rtl/steer_en.sv
// Rider-detection / steering-enable sequencer: IDLE -> WAIT (stable-rider timer) -> STEER.
// Optional macro RIDER_LOST_CNT_EN adds rider_lost_cnt, a saturating count of rider-lost exits from STEER.
module steer_en #(
    parameter bit          fast_sim      = 1'b1,
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [7:0]  WT_HYSTERESIS = 8'h40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_up,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
`ifdef RIDER_LOST_CNT_EN
    ,
    output logic [7:0]  rider_lost_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } state_t;

    localparam logic [12:0] MOUNT_WT = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0] KEEP_WT  = {1'b0, MIN_RIDER_WT} - {5'b0, WT_HYSTERESIS};

    state_t      state_q, state_d;
    logic [25:0] tmr_q, tmr_d;
    logic [11:0] lft_q, rght_q;
    logic        en_steer_q, rider_off_q;

    logic [12:0] sum, diff;
    logic        sum_gt_min, diff_gt_1_4, diff_gt_15_16, tmr_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q  <= 12'h000;
            rght_q <= 12'h000;
        end else if (ld_vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    assign sum  = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff = (lft_q >= rght_q) ? ({1'b0, lft_q} - {1'b0, rght_q})
                                    : ({1'b0, rght_q} - {1'b0, lft_q});

    // Once a rider is aboard the threshold drops by the hysteresis amount.
    assign sum_gt_min    = (state_q == IDLE) ? (sum > MOUNT_WT) : (sum > KEEP_WT);
    assign diff_gt_1_4   = diff > {2'b00, sum[12:2]};
    assign diff_gt_15_16 = diff > (sum - {4'b0000, sum[12:4]});
    assign tmr_full      = fast_sim ? (&tmr_q[14:0]) : (&tmr_q);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (!pwr_up) begin
            state_d = IDLE;
            tmr_d   = 26'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sum_gt_min) begin
                        state_d = WAIT;
                        tmr_d   = 26'd0;
                    end
                end
                WAIT: begin
                    if (!sum_gt_min) begin
                        state_d = IDLE;
                    end else if (diff_gt_1_4) begin
                        tmr_d = 26'd0;
                    end else if (tmr_full) begin
                        state_d = STEER;
                    end else begin
                        tmr_d = tmr_q + 26'd1;
                    end
                end
                STEER: begin
                    if (!sum_gt_min) begin
                        state_d = IDLE;
                    end else if (diff_gt_15_16) begin
                        state_d = WAIT;
                        tmr_d   = 26'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tmr_d   = 26'd0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they track the state flops exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmr_q       <= 26'd0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            en_steer_q  <= (state_d == STEER);
            rider_off_q <= (state_d == IDLE);
        end
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;

`ifdef RIDER_LOST_CNT_EN
    logic [7:0] lost_cnt_q;
    logic       lost_evt;

    assign lost_evt = pwr_up && (state_q == STEER) && !sum_gt_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt_q <= 8'h00;
        end else if (lost_evt && (lost_cnt_q != 8'hFF)) begin
            lost_cnt_q <= lost_cnt_q + 8'd1;
        end
    end

    assign rider_lost_cnt = lost_cnt_q;
`endif

endmodule

// File: doc/steer_en.md
Name: steer_en

Overview:
- Rider-detection and steering-enable sequencer for the balance controller.
- Watches the left/right load-cell readings from the A2D interface and decides when a rider is aboard and balanced.
- Drives rider_off (clears the PID integrator) and en_steer (gates steering into the torque math).
- Sits between the A2D round-robin interface and balance_cntrl.

Parameters:
- fast_sim, 1: when 1, the stable-rider timer terminates after 2^15 clocks; when 0, after 2^26 clocks (1.34 s at 50 MHz).
- MIN_RIDER_WT, 12'h200: sum-of-loads threshold to declare a rider present.
- WT_HYSTERESIS, 8'h40: amount the sum may drop below MIN_RIDER_WT before the rider is declared lost.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous reset, active-low
- pwr_up  in  1  balance system authorized/powered; low forces IDLE
- ld_vld  in  1  one-cycle strobe, new lft_ld/rght_ld pair valid
- lft_ld  in  12  unsigned left load cell
- rght_ld  in  12  unsigned right load cell
- en_steer  out  1  steering enabled to balance_cntrl
- rider_off  out  1  no rider; holds PID integrator at zero

Behaviour:
- Reset is rst_n, asynchronous, active-low; the clock is clk.
- Reset values: state=IDLE, timer=0, load regs=0, en_steer=0, rider_off=1.

Load capture:
- On a clk edge with ld_vld=1, lft_ld/rght_ld are latched into lft_r/rght_r.
- All decisions use the latched values; without ld_vld the previous values are reused.

Arithmetic, all unsigned:
- sum = lft_r + rght_r, 13 bits.
- diff = |lft_r − rght_r|, 13 bits.
- sum_gt_min: in IDLE, sum > MIN_RIDER_WT; in WAIT/STEER, sum > MIN_RIDER_WT − WT_HYSTERESIS.
- diff_gt_1_4 = diff > (sum >> 2).
- diff_gt_15_16 = diff > (sum − (sum >> 4)).

Timer:
- 26-bit up-counter, incremented only in WAIT.
- tmr_full = fast_sim ? &tmr[14:0] : &tmr[25:0].
- The counter stops at terminal count; it never wraps.

FSM (state flops; outputs are Moore-decoded from state):
- IDLE: rider_off=1, en_steer=0.
  - sum_gt_min → WAIT, timer cleared.
- WAIT: rider_off=0, en_steer=0.
  - !sum_gt_min → IDLE.
  - else diff_gt_1_4 → stay, timer cleared.
  - else tmr_full → STEER.
  - else timer+1.
- STEER: rider_off=0, en_steer=1.
  - !sum_gt_min → IDLE.
  - else diff_gt_15_16 → WAIT, timer cleared.
- Priority in every state: pwr_up low > !sum_gt_min > diff test > timer.
- pwr_up=0 in any state: synchronous → IDLE, timer cleared, regardless of loads.
- Encoding 2'b11 is illegal and recovers to IDLE.

Latency:
- Capture edge N; the state/outputs change at edge N+1.
- en_steer rises on the edge after tmr_full is seen in WAIT.
- Reset mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- Macro: RIDER_LOST_CNT_EN.
- Defined:
  - Adds output rider_lost_cnt[7:0].
  - Counts STEER→IDLE transitions caused by !sum_gt_min; pwr_up-forced exits are not counted.
  - Saturates at 8'hFF.
  - Reset to 0 by rst_n only.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-STEER → en_steer=0, rider_off=1 immediately; both hold after release with loads=0.
- Mount: fast_sim=1, pwr_up=1, lft=rght=12'h180 (sum 0x300), ld_vld pulsed every 100 clocks.
  - rider_off falls 1 clock after the first capture.
  - en_steer rises exactly 32768 clocks later, ±1 for the terminal-count edge.
- Unbalanced in WAIT: lft=12'h200, rght=12'h0C0 (diff 0x140 > 0xB0) → timer held 0, en_steer stays 0.
  - Return to 12'h160/12'h160 → en_steer asserts after a full 32768-clock count.
- Step-off in STEER: lft=12'h2E0, rght=12'h010 (diff 0x2D0 > 0x2C1) → WAIT next clock, en_steer=0, rider_off=0.
- Hysteresis in STEER:
  - sum=0x1D0 → remain in STEER.
  - sum=0x1B0 → IDLE, rider_off=1.
  - In IDLE, sum=0x1F0 must not leave IDLE; sum=0x201 → WAIT.
- pwr_up drop in WAIT at timer≈20000 → IDLE next clock.
  - Re-raise pwr_up with the rider still present → WAIT, and a full 32768-clock count is needed before en_steer.
  - With RIDER_LOST_CNT_EN, rider_lost_cnt is unchanged by this exit.
